// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory pins seen by the arbiter.
// The master side is the requesters plus memory; the slave side is the arbiter.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              valid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              valid1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        input  gnt0, valid0, rdata0, gnt1, valid1, rdata1,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        output gnt0, valid0, rdata0, gnt1, valid1, rdata1,
        output mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the data memory: one access per
// IDLE -> ACCESS -> RESP pass, with all handshake and memory strobes decoded from state.
module data_mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input logic              clk,
    input logic              reset,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        sel_d    = sel_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the port that did not win last time goes next.
                    sel_d   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    last_d  = sel_d;
                    we_d    = sel_d ? bus.we1    : bus.we0;
                    addr_d  = sel_d ? bus.addr1  : bus.addr0;
                    wdata_d = sel_d ? bus.wdata1 : bus.wdata0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (sel_q) rdata1_d = bus.mem_rdata;
                    else       rdata0_d = bus.mem_rdata;
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address and write data stay on the latched values between accesses.
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = (state_q == ACCESS) &&  we_q;
    assign bus.mem_re    = (state_q == ACCESS) && !we_q;
    assign bus.gnt0      = (state_q == ACCESS) && !sel_q;
    assign bus.gnt1      = (state_q == ACCESS) &&  sel_q;
    assign bus.valid0    = (state_q == RESP)   && !sel_q;
    assign bus.valid1    = (state_q == RESP)   &&  sel_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
endmodule
